csr_access_unit: RTL and testbench

Multi-cycle execution unit for the RISC-V Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms). It accepts a decoded CSR instruction from ID, reads the addressed CSR from the CSR/register file, computes the new CSR value, and then issues one write-back beat. That beat carries the CSR write (`csr_waddr`/`csr_wdata`) and the rd write (`rd_waddr`/`rd_wdata`). It sits between ID and the CSR/register file, driving the file's CSR write port and its CSR read address, and contributing one source to the rd write data.

---
 rtl/csr_access_unit.sv | 127 ++++++++++++
 tb/tb_csr_access_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - Zicsr CSRRW/RS/RC(+I) unit, IDLE/READ/WB; optional macro CSR_RO_CHECK_EN
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef MDISABLE
`define MDISABLE {`CSR_ADDR_WIDTH{1'b0}}
`endif
`ifndef ZERO_REG
`define ZERO_REG {`REG_ADDR_WIDTH{1'b0}}
`endif

module csr_access_unit (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [2:0]                   funct3,
  input  logic [`CSR_ADDR_WIDTH-1:0]   csr_addr,
  input  logic [`REG_ADDR_WIDTH-1:0]   rs1_idx,
  input  logic [`DATA_WIDTH-1:0]       rs1_val,
  input  logic [`REG_ADDR_WIDTH-1:0]   rd_idx,
  output logic [`CSR_ADDR_WIDTH-1:0]   csr_raddr,
  input  logic [`DATA_WIDTH-1:0]       csr_rdata,
  output logic [`CSR_ADDR_WIDTH-1:0]   csr_waddr,
  output logic [`DATA_WIDTH-1:0]       csr_wdata,
  output logic [`REG_ADDR_WIDTH-1:0]   rd_waddr,
  output logic [`DATA_WIDTH-1:0]       rd_wdata,
  output logic                         done,
  output logic                         illegal
);

  typedef enum logic [1:0] {IDLE, READ, WB} state_t;

  state_t                       state;
  logic [1:0]                   op_q;
  logic [`CSR_ADDR_WIDTH-1:0]   addr_q;
  logic [`REG_ADDR_WIDTH-1:0]   rd_q;
  logic [`DATA_WIDTH-1:0]       opnd_q;
  logic                         wr_en_q;
  logic [`DATA_WIDTH-1:0]       new_val;
  logic                         ill_now;

  assign req_ready = (state == IDLE);
  assign csr_raddr = (state == READ) ? addr_q : `MDISABLE;

  // New CSR value from the live read data, plus the trap decision for this instruction
  always_comb begin
    new_val = opnd_q;
    case (op_q)
      2'b10:   new_val = csr_rdata | opnd_q;
      2'b11:   new_val = csr_rdata & ~opnd_q;
      default: new_val = opnd_q;
    endcase
    // funct3 low bits 00 covers both reserved encodings 000 and 100
    ill_now = (op_q == 2'b00);
`ifdef CSR_RO_CHECK_EN
    if (wr_en_q && (addr_q[`CSR_ADDR_WIDTH-1 -: 2] == 2'b11))
      ill_now = 1'b1;
`endif
  end

  // Sequencer: latch in IDLE, read/compute in READ, present the write-back beat during WB
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= 2'b00;
      addr_q    <= '0;
      rd_q      <= '0;
      opnd_q    <= '0;
      wr_en_q   <= 1'b0;
      csr_waddr <= `MDISABLE;
      csr_wdata <= '0;
      rd_waddr  <= `ZERO_REG;
      rd_wdata  <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= funct3[1:0];
            addr_q  <= csr_addr;
            rd_q    <= rd_idx;
            opnd_q  <= funct3[2] ? {{(`DATA_WIDTH-`REG_ADDR_WIDTH){1'b0}}, rs1_idx} : rs1_val;
            // Set/clear forms with rs1/zimm of zero must not write the CSR
            wr_en_q <= (funct3[1:0] == 2'b01) || (rs1_idx != '0);
            state   <= READ;
          end
        end
        READ: begin
          if (ill_now) begin
            csr_waddr <= `MDISABLE;
            csr_wdata <= '0;
            rd_waddr  <= `ZERO_REG;
            rd_wdata  <= '0;
            illegal   <= 1'b1;
          end else begin
            csr_waddr <= wr_en_q ? addr_q : `MDISABLE;
            csr_wdata <= new_val;
            rd_waddr  <= rd_q;
            rd_wdata  <= csr_rdata;
            done      <= 1'b1;
          end
          state <= WB;
        end
        WB: begin
          // rd_wdata is OR-merged in the file, so it must be zero outside WB
          csr_waddr <= `MDISABLE;
          csr_wdata <= '0;
          rd_waddr  <= `ZERO_REG;
          rd_wdata  <= '0;
          done      <= 1'b0;
          illegal   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb/tb_csr_access_unit.sv - self-checking bench for csr_access_unit with CSR/register file model
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  funct3 = 3'b000;
  logic [11:0] csr_addr = 12'h000;
  logic [4:0]  rs1_idx = 5'd0;
  logic [31:0] rs1_val = 32'h0;
  logic [4:0]  rd_idx = 5'd0;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        done;
  logic        illegal;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit init_mem = 1'b1;

  localparam logic [31:0] SENT = 32'hA5A5A5A5;

  csr_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_val(rs1_val),
    .rd_idx(rd_idx), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // CSR file / register file environment; read-only CSR space silently ignores writes
  logic [31:0] csr_mem [0:4095];
  logic [31:0] xreg [0:31];
  assign csr_rdata = csr_mem[csr_raddr];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'h0;
      for (int i = 0; i < 32; i++) xreg[i] <= SENT;
      csr_mem[12'h340] <= 32'h12345678;
      csr_mem[12'h300] <= 32'h00000001;
      csr_mem[12'hF11] <= 32'h013109F5;
    end else begin
      if (csr_waddr != 12'h000 && csr_waddr[11:10] != 2'b11) csr_mem[csr_waddr] <= csr_wdata;
      if (rd_waddr != 5'd0) xreg[rd_waddr] <= rd_wdata;
    end
  end

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", n, act, exp, cyc);
    end
  endfunction

  // Reference model: an instruction in flight is read one cycle after accept and retires two cycles after
  typedef struct {
    int          acc;
    logic [11:0] addr;
    logic [31:0] newv;
    logic [31:0] oldv;
    logic [4:0]  rd;
    bit          wr;
    bit          ill;
  } req_t;

  req_t pend[$];
  int acc_log[$];
  logic [31:0] mcsr [0:4095];

  initial begin
    logic [31:0] e_raddr, e_waddr, e_wdata, e_rdaddr, e_rdata;
    bit e_ready, e_done, e_ill, wb;
    req_t r;
    logic [31:0] opnd;
    for (int i = 0; i < 4096; i++) mcsr[i] = 32'h0;
    mcsr[12'h340] = 32'h12345678;
    mcsr[12'h300] = 32'h00000001;
    mcsr[12'hF11] = 32'h013109F5;
    forever begin
      @(negedge clk);
      e_ready = (pend.size() == 0);
      e_raddr = 0; e_waddr = 0; e_wdata = 0; e_rdaddr = 0; e_rdata = 0;
      e_done = 0; e_ill = 0; wb = 0;
      if (pend.size() != 0) begin
        if (pend[0].acc + 1 == cyc) e_raddr = {20'h0, pend[0].addr};
        if (pend[0].acc + 2 == cyc) begin
          wb = 1;
          if (pend[0].ill) e_ill = 1;
          else begin
            e_done   = 1;
            e_waddr  = pend[0].wr ? {20'h0, pend[0].addr} : 32'h0;
            e_wdata  = pend[0].newv;
            e_rdaddr = {27'h0, pend[0].rd};
            e_rdata  = pend[0].oldv;
          end
        end
      end
      if (chk_en) begin
        chk("req_ready", {31'h0, req_ready}, {31'h0, e_ready});
        chk("csr_raddr", {20'h0, csr_raddr}, e_raddr);
        chk("csr_waddr", {20'h0, csr_waddr}, e_waddr);
        chk("csr_wdata", csr_wdata, e_wdata);
        chk("rd_waddr", {27'h0, rd_waddr}, e_rdaddr);
        chk("rd_wdata", rd_wdata, e_rdata);
        chk("done", {31'h0, done}, {31'h0, e_done});
        chk("illegal", {31'h0, illegal}, {31'h0, e_ill});
      end
      if (wb) begin
        if (!pend[0].ill && pend[0].wr && pend[0].addr[11:10] != 2'b11)
          mcsr[pend[0].addr] = pend[0].newv;
        void'(pend.pop_front());
      end
      if (rst) begin
        pend.delete();
      end else if (req_valid && e_ready) begin
        opnd   = funct3[2] ? {27'h0, rs1_idx} : rs1_val;
        r.acc  = cyc;
        r.addr = csr_addr;
        r.rd   = rd_idx;
        r.oldv = mcsr[csr_addr];
        r.wr   = (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
        case (funct3[1:0])
          2'b10:   r.newv = r.oldv | opnd;
          2'b11:   r.newv = r.oldv & ~opnd;
          default: r.newv = opnd;
        endcase
        r.ill = (funct3 == 3'b000) || (funct3 == 3'b100);
`ifdef CSR_RO_CHECK_EN
        if (r.wr && csr_addr[11:10] == 2'b11) r.ill = 1;
`endif
        pend.push_back(r);
        acc_log.push_back(cyc);
      end
      cyc++;
    end
  end

  task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r1,
                        input logic [31:0] v, input logic [4:0] rd, input bit hold);
    bit got = 0;
    funct3 = f3; csr_addr = a; rs1_idx = r1; rs1_val = v; rd_idx = rd; req_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready) got = 1;
      @(posedge clk); #1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout got=0 want=1 cyc=%0d", cyc);
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; init_mem = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("reset_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_done", {31'h0, done}, 32'h0);
    @(posedge clk); #1;

    do_req(3'b001, 12'h340, 5'd1, 32'hDEADBEEF, 5'd5, 0); settle();  // CSRRW mscratch
    do_req(3'b010, 12'h300, 5'd3, 32'h00000008, 5'd6, 0); settle();  // CSRRS mstatus
    do_req(3'b111, 12'h300, 5'd0, 32'hFFFFFFFF, 5'd8, 0); settle();  // CSRRCI zimm 0
    do_req(3'b010, 12'hF11, 5'd0, 32'hFFFFFFFF, 5'd7, 0); settle();  // CSRRS mvendorid x0
    do_req(3'b001, 12'hF11, 5'd1, 32'h00000000, 5'd9, 0); settle();  // CSRRW read-only
    do_req(3'b000, 12'h300, 5'd2, 32'hFFFFFFFF, 5'd10, 0); settle(); // reserved funct3
    do_req(3'b001, 12'h340, 5'd4, 32'h11111111, 5'd0, 0); settle();  // rd = x0
    do_req(3'b110, 12'h300, 5'd5, 32'hFFFFFFFF, 5'd11, 0); settle(); // CSRRSI zimm 5

    do_req(3'b011, 12'h300, 5'd2, 32'h00000001, 5'd12, 1);          // back-to-back pair
    do_req(3'b101, 12'h340, 5'd31, 32'hFFFFFFFF, 5'd13, 0);
    settle();
    chk("b2b_gap", acc_log[acc_log.size()-1] - acc_log[acc_log.size()-2], 32'd3);

    do_req(3'b001, 12'h340, 5'd1, 32'h00000055, 5'd14, 0);          // abort in READ
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_done", {31'h0, done}, 32'h0);
    chk("abort_waddr", {20'h0, csr_waddr}, 32'h0);
    chk("abort_rdaddr", {27'h0, rd_waddr}, 32'h0);
    settle();

    chk("x5", xreg[5], 32'h12345678);
    chk("x6", xreg[6], 32'h00000001);
    chk("x8", xreg[8], 32'h00000009);
    chk("x7", xreg[7], 32'h013109F5);
`ifdef CSR_RO_CHECK_EN
    chk("x9", xreg[9], SENT);
`else
    chk("x9", xreg[9], 32'h013109F5);
`endif
    chk("x10", xreg[10], SENT);
    chk("x0", xreg[0], SENT);
    chk("x11", xreg[11], 32'h00000009);
    chk("x12", xreg[12], 32'h0000000D);
    chk("x13", xreg[13], 32'h11111111);
    chk("x14", xreg[14], SENT);
    chk("mscratch", csr_mem[12'h340], 32'h0000001F);
    chk("mstatus", csr_mem[12'h300], 32'h0000000C);
    chk("mvendorid", csr_mem[12'hF11], 32'h013109F5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1);
  end

endmodule
